// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N_CH-to-1 valid/ready arbiter with a registered 1-entry output stage.
// Ports: clk, rst (async high); in_data_i/in_valid_i/in_ready_o per channel;
// out_data_o/out_sel_o/out_valid_o with out_ready_i downstream.
// MODE 0 = fixed priority (lowest index wins), MODE 1 = round-robin from ptr.
module rr_mux_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int N_CH       = 4,
    parameter int MODE       = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data_i,
    input  logic [N_CH-1:0]            in_valid_i,
    output logic [N_CH-1:0]            in_ready_o,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] out_sel_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [SEL_W-1:0]      ptr_q, ptr_d;

    logic [N_CH-1:0]       masked;
    logic [N_CH-1:0]       grant;
    logic [SEL_W-1:0]      m_idx, f_idx, gnt_idx;
    logic                  m_any, f_any;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  can_load;
    logic                  xfer;

    // Two lowest-index searches: one over channels at or above ptr, one
    // over all channels. The unmasked result is the wrap-around fallback.
    always_comb begin
        masked = '0;
        m_any  = 1'b0;
        m_idx  = '0;
        f_any  = 1'b0;
        f_idx  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            masked[i] = in_valid_i[i] && (SEL_W'(i) >= ptr_q);
            if (masked[i]) begin
                m_any = 1'b1;
                m_idx = SEL_W'(i);
            end
            if (in_valid_i[i]) begin
                f_any = 1'b1;
                f_idx = SEL_W'(i);
            end
        end
    end

    // One-hot grant and the matching data word.
    always_comb begin
        gnt_idx  = m_any ? m_idx : f_idx;
        grant    = '0;
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (f_any && (gnt_idx == SEL_W'(i))) begin
                grant[i] = 1'b1;
                gnt_data = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign can_load   = (state_q == EMPTY) || (out_ready_i && out_valid_o);
    assign xfer       = can_load && f_any && !rst;
    assign in_ready_o = (can_load && !rst) ? grant : '0;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = FULL;
            data_d  = gnt_data;
            sel_d   = gnt_idx;
            // Explicit wrap keeps ptr below N_CH for non-power-of-2 sizes.
            if (gnt_idx == SEL_W'(N_CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + SEL_W'(1);
            end
        end else if (state_q == FULL && out_ready_i) begin
            state_d = EMPTY;
        end
        if (MODE != 1) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid_o = (state_q == FULL);
    assign out_data_o  = data_q;
    assign out_sel_o   = sel_q;
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed vectors for rr_mux_arb in round-robin, fixed
// priority, 3-channel and 1-channel configurations.
`timescale 1ns/1ps
module tb_rr_mux_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // round-robin, 4 channels
    logic [127:0] a_data;
    logic [3:0]   a_valid, a_ready;
    logic [31:0]  a_odata;
    logic [1:0]   a_sel;
    logic         a_ovalid, a_ordy;
    // fixed priority, 4 channels
    logic [127:0] b_data;
    logic [3:0]   b_valid, b_ready;
    logic [31:0]  b_odata;
    logic [1:0]   b_sel;
    logic         b_ovalid, b_ordy;
    // round-robin, 3 channels
    logic [95:0]  c_data;
    logic [2:0]   c_valid, c_ready;
    logic [31:0]  c_odata;
    logic [1:0]   c_sel;
    logic         c_ovalid, c_ordy;
    // single channel, 8-bit
    logic [7:0]   d_data;
    logic [0:0]   d_valid, d_ready;
    logic [7:0]   d_odata;
    logic [0:0]   d_sel;
    logic         d_ovalid, d_ordy;

    rr_mux_arb #(.DATA_WIDTH(32), .N_CH(4), .MODE(1)) u_a (
        .clk(clk), .rst(rst), .in_data_i(a_data), .in_valid_i(a_valid),
        .in_ready_o(a_ready), .out_data_o(a_odata), .out_sel_o(a_sel),
        .out_valid_o(a_ovalid), .out_ready_i(a_ordy));
    rr_mux_arb #(.DATA_WIDTH(32), .N_CH(4), .MODE(0)) u_b (
        .clk(clk), .rst(rst), .in_data_i(b_data), .in_valid_i(b_valid),
        .in_ready_o(b_ready), .out_data_o(b_odata), .out_sel_o(b_sel),
        .out_valid_o(b_ovalid), .out_ready_i(b_ordy));
    rr_mux_arb #(.DATA_WIDTH(32), .N_CH(3), .MODE(1)) u_c (
        .clk(clk), .rst(rst), .in_data_i(c_data), .in_valid_i(c_valid),
        .in_ready_o(c_ready), .out_data_o(c_odata), .out_sel_o(c_sel),
        .out_valid_o(c_ovalid), .out_ready_i(c_ordy));
    rr_mux_arb #(.DATA_WIDTH(8), .N_CH(1), .MODE(1)) u_d (
        .clk(clk), .rst(rst), .in_data_i(d_data), .in_valid_i(d_valid),
        .in_ready_o(d_ready), .out_data_o(d_odata), .out_sel_o(d_sel),
        .out_valid_o(d_ovalid), .out_ready_i(d_ordy));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic clear_inputs();
        a_data = '0; a_valid = '0; a_ordy = 1'b0;
        b_data = '0; b_valid = '0; b_ordy = 1'b0;
        c_data = '0; c_valid = '0; c_ordy = 1'b0;
        d_data = '0; d_valid = '0; d_ordy = 1'b0;
    endtask

    // Leaves time at 1 ns after a rising edge with rst low.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]   valid;
        logic         ordy;
        logic [127:0] data;
        logic [3:0]   exp_rdy;
        logic         exp_v;
        logic [31:0]  exp_d;
        logic [1:0]   exp_s;
    } vec_t;

    vec_t vt[10];

    int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
    int exp_c[4]  = '{0, 2, 0, 2};

    initial begin
        vt[0] = '{4'b0100, 1'b1,
                  {32'h10000003, 32'hDEADBEEF, 32'h10000001, 32'h10000000},
                  4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
        vt[1] = '{4'b1111, 1'b1, pk(32'h20000000),
                  4'b1000, 1'b1, 32'h20000003, 2'd3};
        vt[2] = '{4'b0000, 1'b1, pk(32'h20000000),
                  4'b0000, 1'b0, 32'h20000003, 2'd3};
        vt[3] = '{4'b0000, 1'b0, pk(32'h20000000),
                  4'b0000, 1'b0, 32'h20000003, 2'd3};
        vt[4] = '{4'b0010, 1'b0, pk(32'h30000000),
                  4'b0010, 1'b1, 32'h30000001, 2'd1};
        vt[5] = '{4'b1111, 1'b0, pk(32'h40000000),
                  4'b0000, 1'b1, 32'h30000001, 2'd1};
        vt[6] = '{4'b1111, 1'b0, pk(32'h40000000),
                  4'b0000, 1'b1, 32'h30000001, 2'd1};
        vt[7] = '{4'b1111, 1'b0, pk(32'h40000000),
                  4'b0000, 1'b1, 32'h30000001, 2'd1};
        vt[8] = '{4'b1111, 1'b1, pk(32'h40000000),
                  4'b0100, 1'b1, 32'h40000002, 2'd2};
        vt[9] = '{4'b0000, 1'b1, pk(32'h40000000),
                  4'b0000, 1'b0, 32'h40000002, 2'd2};

        // reset state, with requests present during reset
        clear_inputs();
        rst = 1'b1;
        a_valid = 4'b1111;
        a_ordy = 1'b1;
        #12;
        chk("rst out_valid", 32'(a_ovalid), 32'd0);
        chk("rst out_data", a_odata, 32'd0);
        chk("rst out_sel", 32'(a_sel), 32'd0);
        chk("rst in_ready", 32'(a_ready), 32'd0);
        do_reset();

        // table: single channel, ptr advance, drain, backpressure
        for (int i = 0; i < 10; i++) begin
            a_valid = vt[i].valid;
            a_ordy  = vt[i].ordy;
            a_data  = vt[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), 32'(a_ready),
                32'(vt[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 32'(a_ovalid),
                32'(vt[i].exp_v));
            chk($sformatf("vec%0d out_data", i), a_odata, vt[i].exp_d);
            chk($sformatf("vec%0d out_sel", i), 32'(a_sel),
                32'(vt[i].exp_s));
        end

        // round-robin fairness from reset, no bubbles
        do_reset();
        a_valid = 4'b1111;
        a_ordy  = 1'b1;
        a_data  = pk(32'h50000000);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d out_valid", i), 32'(a_ovalid), 32'd1);
            chk($sformatf("rr%0d out_sel", i), 32'(a_sel), 32'(exp_rr[i]));
            chk($sformatf("rr%0d out_data", i), a_odata,
                32'h50000000 + 32'(exp_rr[i]));
        end

        // asynchronous reset while holding a word
        do_reset();
        a_valid = 4'b0001;
        a_ordy  = 1'b0;
        a_data  = {96'd0, 32'h12345678};
        @(posedge clk);
        #1;
        chk("pre-rst out_data", a_odata, 32'h12345678);
        chk("pre-rst out_valid", 32'(a_ovalid), 32'd1);
        a_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        chk("async out_valid", 32'(a_ovalid), 32'd0);
        chk("async out_data", a_odata, 32'd0);
        chk("async out_sel", 32'(a_sel), 32'd0);
        chk("async in_ready", 32'(a_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        a_ordy = 1'b1;
        a_data = pk(32'h60000000);
        #1;
        chk("post-rst in_ready", 32'(a_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post-rst out_sel", 32'(a_sel), 32'd0);
        chk("post-rst out_data", a_odata, 32'h60000000);

        // fixed priority
        do_reset();
        b_valid = 4'b1010;
        b_ordy  = 1'b1;
        b_data  = pk(32'h70000000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("fp%0d in_ready", i), 32'(b_ready), 32'b0010);
            @(posedge clk);
            #1;
            chk($sformatf("fp%0d out_sel", i), 32'(b_sel), 32'd1);
            chk($sformatf("fp%0d out_valid", i), 32'(b_ovalid), 32'd1);
        end

        // 3-channel wrap
        do_reset();
        c_valid = 3'b101;
        c_ordy  = 1'b1;
        c_data  = {32'h82, 32'h81, 32'h80};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("n3_%0d in_ready", i), 32'(c_ready),
                (exp_c[i] == 0) ? 32'b001 : 32'b100);
            @(posedge clk);
            #1;
            chk($sformatf("n3_%0d out_sel", i), 32'(c_sel), 32'(exp_c[i]));
            chk($sformatf("n3_%0d out_data", i), c_odata,
                32'h80 + 32'(exp_c[i]));
        end

        // single channel pipeline register
        do_reset();
        d_valid = 1'b1;
        d_ordy  = 1'b1;
        d_data  = 8'h5A;
        @(negedge clk);
        chk("n1 in_ready", 32'(d_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("n1 out_data", 32'(d_odata), 32'h5A);
        chk("n1 out_sel", 32'(d_sel), 32'd0);
        chk("n1 out_valid", 32'(d_ovalid), 32'd1);
        d_ordy = 1'b0;
        d_data = 8'hA5;
        @(negedge clk);
        chk("n1 stall in_ready", 32'(d_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("n1 stall out_data", 32'(d_odata), 32'h5A);
        d_ordy = 1'b1;
        @(posedge clk);
        #1;
        chk("n1 reload out_data", 32'(d_odata), 32'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
